// File: rtl/cla_add16_seq.sv
// Multi-cycle W-bit add/subtract sequencer that reuses one 4-bit carry-lookahead
// slice per clock, least-significant nibble first, chaining the carry in a register.

module CLA_Add4_gen (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cIn,
  output logic [3:0] s,
  output logic       cOut
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // All carries are derived directly from cIn so the slice depth stays flat.
  assign c[0] = cIn;
  assign c[1] = g[0] | (p[0] & cIn);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
  assign cOut = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cIn);

  assign s = p ^ c;

endmodule

module cla_add16_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cOut,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT state;
  stateT nextState;

  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic [W-1:0]  acc;
  logic [W-1:0]  accMerged;
  logic          carry;
  logic [IW-1:0] idx;
  logic [IW+1:0] sliceBase;
  logic [3:0]    sliceX;
  logic [3:0]    sliceY;
  logic [3:0]    sliceS;
  logic          sliceCOut;
  logic          lastNibble;

  assign sliceBase  = {idx, 2'b00};
  assign sliceX     = opA[sliceBase +: 4];
  assign sliceY     = opB[sliceBase +: 4];
  assign lastNibble = (idx == IW'(NIBBLES - 1));

  CLA_Add4_gen slice (
    .x    (sliceX),
    .y    (sliceY),
    .cIn  (carry),
    .s    (sliceS),
    .cOut (sliceCOut)
  );

  always_comb begin
    accMerged = acc;
    accMerged[sliceBase +: 4] = sliceS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (lastNibble) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: opB holds ~b and the carry starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA   <= '0;
      opB   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cOut  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opA   <= a;
          opB   <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
          acc   <= '0;
        end
      end else begin
        acc   <= accMerged;
        carry <= sliceCOut;
        idx   <= idx + IW'(1);
        if (lastNibble) begin
          idx  <= '0;
          sum  <= accMerged;
          cOut <= sliceCOut;
          ovf  <= (opA[W-1] == opB[W-1]) && (sliceS[3] != opA[W-1]);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_add16_seq.sv
// Directed scoreboard bench for cla_add16_seq: expected results are queued at
// start and popped when done pulses.

module tb_cla_add16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cOut;
  logic        ovf;

  typedef struct packed {
    logic [15:0] sum;
    logic        cOut;
    logic        ovf;
  } expectT;

  expectT      scoreboard[$];
  int          total;
  int          bad;
  logic [15:0] prevSum;

  cla_add16_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cOut  (cOut),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; drives one start and returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn, input logic subIn);
    expectT      e;
    logic [15:0] bEff;
    logic [16:0] full;
    bEff   = subIn ? ~bIn : bIn;
    full   = {1'b0, aIn} + {1'b0, bEff} + {16'd0, subIn};
    e.sum  = full[15:0];
    e.cOut = full[16];
    e.ovf  = (aIn[15] == bEff[15]) && (full[15] != aIn[15]);
    scoreboard.push_back(e);
    a     = aIn;
    b     = bIn;
    sub   = subIn;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkValue("acceptBusy", {31'd0, busy}, 32'd1);
    checkValue("doneCleared", {31'd0, done}, 32'd0);
  endtask

  task automatic checkOutput(input int expLatency);
    int     cycles;
    expectT e;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (!done) begin
        checkValue("busyRun", {31'd0, busy}, 32'd1);
        checkValue("sumHold", {16'd0, sum}, {16'd0, prevSum});
      end
    end
    checkValue("latency", cycles, expLatency);
    if (scoreboard.size() == 0) begin
      checkValue("scoreboardEmpty", 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      checkValue("sum", {16'd0, sum}, {16'd0, e.sum});
      checkValue("cOut", {31'd0, cOut}, {31'd0, e.cOut});
      checkValue("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      checkValue("busyAtDone", {31'd0, busy}, 32'd0);
      prevSum = e.sum;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    prevSum = 16'h0000;
    rst     = 1'b1;
    start   = 1'b0;
    sub     = 1'b0;
    a       = 16'h0000;
    b       = 16'h0000;
    #1;
    checkValue("resetSum", {16'd0, sum}, 32'd0);
    checkValue("resetBusy", {31'd0, busy}, 32'd0);
    checkValue("resetDone", {31'd0, done}, 32'd0);
    checkValue("resetFlags", {30'd0, cOut, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h000A, 16'h0001, 1'b0);
    checkOutput(4);
    @(negedge clk);
    checkValue("doneOnePulse", {31'd0, done}, 32'd0);
    checkValue("sumIdleHold", {16'd0, sum}, 32'h000B);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput(4);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput(4);
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    checkOutput(4);
    // Issued on the done cycle of the previous operation: back-to-back accept.
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    checkOutput(4);

    @(negedge clk);
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    a     = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput(2);
    @(negedge clk);
    checkValue("ignoredStartBusy", {31'd0, busy}, 32'd0);
    checkValue("ignoredStartDone", {31'd0, done}, 32'd0);

    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(scoreboard.pop_back());
    prevSum = 16'h0000;
    checkValue("midResetSum", {16'd0, sum}, 32'd0);
    checkValue("midResetBusy", {31'd0, busy}, 32'd0);
    checkValue("midResetDone", {31'd0, done}, 32'd0);
    checkValue("midResetFlags", {30'd0, cOut, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkValue("noDoneAfterReset", {31'd0, done}, 32'd0);
    checkValue("idleAfterReset", {31'd0, busy}, 32'd0);

    applyStimulus(16'h0F0F, 16'h0101, 1'b1);
    checkOutput(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
